multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core. Sequences the shared ALU, the unified instruction/data memory port, the instruction register and the register file across several cycles per instruction.
- Drives immsrc to the immediate extender (I=00, S=01, B=10, J=11) and alucontrol to the ALU.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
- Stalls on a memory-ready handshake. Flags unsupported opcodes.

Parameters:
- RESET_STATE, 0 (FETCH), state entered on reset; kept at 0 for the shipped core.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0], from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, current cycle
- mem_ready  in  1  memory completes current access this cycle
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address mux: 0=PC, 1=ALU result register
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable
- resultsrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- alusrca  out  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1 data
- alusrcb  out  2  ALU B mux: 00=rs2 data, 01=immext, 10=constant 4
- immsrc  out  2  extender format select
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Moore FSM, binary-encoded states:
  - FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Reset: rst_n low forces state=FETCH asynchronously.
  - While rst_n is low, pcwrite, memwrite, irwrite, regwrite and illegal_op are 0.
  - Mux selects take their FETCH values.
- Outputs by state. Any select not listed is 00/0; all enables default to 0.
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=add, resultsrc=10.
    - irwrite=pcupdate=mem_ready.
    - mem_ready=0: remain in FETCH. mem_ready=1: go to DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=add (branch target precompute).
    - Next state: lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; beq -> BEQ; jal -> JAL.
    - Any other op: illegal_op=1 this cycle, next FETCH.
  - MEMADR: alusrca=10, alusrcb=01, aluop=add.
    - Next: MEMREAD if op=0000011, MEMWRITE if op=0100011.
  - MEMREAD: adrsrc=1, resultsrc=00. Hold until mem_ready=1, then MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Next FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00.
    - memwrite=1 held every cycle until mem_ready=1 (inclusive), then FETCH.
  - EXECR: alusrca=10, alusrcb=00, aluop=funct. Next ALUWB.
  - EXECI: alusrca=10, alusrcb=01, aluop=funct. Next ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Next FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00, branch=1. Next FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcupdate=1. Next ALUWB.
- pcwrite = pcupdate | (branch & zero).
- immsrc: combinational from op in every state.
  - lw/I-ALU=00, sw=01, beq=10, jal=11, others=00.
- ALU decode:
  - aluop add -> 000; aluop sub -> 001.
  - aluop funct, by funct3:
    - 000: sub if (op[5] & funct7b5), else add.
    - 010: slt (101). 110: or (011). 111: and (010).
    - Other funct3: 000, no flag.
- Latency with mem_ready held 1: lw 5, sw 4, R 4, I 4, beq 3, jal 4 cycles.
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset asserted mid-instruction aborts it. No partial regwrite/memwrite after the asynchronous edge.
- mem_ready is ignored in states that make no memory access.

Test Plan:
- Reset, then lw (op=0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regwrite=1 only in cycle 5 with resultsrc=01; immsrc=00.
- sw (op=0100011) with mem_ready low 2 cycles in MEMWRITE -> memwrite=1 for 3 consecutive cycles, then FETCH; immsrc=01; regwrite never 1.
- R-type sub (funct3=000, funct7b5=1) -> alucontrol=001 in EXECR. I-type addi with funct7b5=1 -> alucontrol=000. funct3=111 -> 010.
- beq with zero=1 -> pcwrite=1 in BEQ (cycle 3), immsrc=10. Repeat with zero=0 -> pcwrite=0.
- jal (op=1101111) -> pcwrite=1 in JAL, regwrite=1 in the following ALUWB, immsrc=11. op=0000000 -> illegal_op pulse in DECODE, then FETCH.
- Assert rst_n=0 during MEMWRITE -> memwrite drops immediately, state=FETCH. FETCH with mem_ready=0 for 3 cycles -> irwrite/pcwrite stay 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM of the multicycle RV32I core. Sequences the shared ALU,
//   the unified instruction/data memory port, the instruction register and the
//   register file over several cycles per instruction (lw, sw, R-type, I-type
//   ALU, beq, jal). Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op, funct3, funct7b5  instruction fields from the instruction register
//   zero                  ALU zero flag (current cycle)
//   mem_ready             memory completes the current access this cycle
//   pcwrite, adrsrc, memwrite, irwrite, regwrite   datapath enables / address mux
//   resultsrc, alusrca, alusrcb, immsrc, alucontrol datapath selects
//   illegal_op            one-cycle pulse in DECODE on an unsupported opcode
//   dbg_state             current FSM state (encoding below), for observation
//
// Handshake: mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE; the
// state holds and the access stays presented until a cycle with mem_ready=1,
// which completes the access and lets the FSM advance at the next edge.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t state_q, state_d;

  // Raw Moore outputs before reset gating.
  logic       pcupdate, branch, irwrite_raw, regwrite_raw, memwrite_raw, illegal_raw;
  logic [1:0] aluop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_d = MEMREAD;
        else if (op == OP_SW) state_d = MEMWRITE;
        else                  state_d = FETCH;
      end
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Output logic (Moore, plus zero/mem_ready qualification of enables)
  always_comb begin
    pcupdate     = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    adrsrc       = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    aluop        = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        irwrite_raw = mem_ready;
        pcupdate    = mem_ready;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        illegal_raw = !(op == OP_LW || op == OP_SW || op == OP_R ||
                        op == OP_I  || op == OP_BEQ || op == OP_JAL);
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD:  adrsrc = 1'b1;
      MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECR: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB:    regwrite_raw = 1'b1;
      BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are forced low for the whole time rst_n is asserted, not just
  // after the state register clears, so no partial write escapes.
  assign pcwrite    = rst_n & (pcupdate | (branch & zero));
  assign irwrite    = rst_n & irwrite_raw;
  assign regwrite   = rst_n & regwrite_raw;
  assign memwrite   = rst_n & memwrite_raw;
  assign illegal_op = rst_n & illegal_raw;
  assign dbg_state  = state_q;

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // ALU decoder. op[5] separates R-type (sub allowed) from I-type (addi only).
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      ALUOP_SUB: alucontrol = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_op;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] dbg_state;

  int checks = 0;
  int failures = 0;

  // Expected {state[3:0], pcwrite, adrsrc, memwrite, irwrite, regwrite,
  //           resultsrc, alusrca, alusrcb, immsrc, alucontrol, illegal_op}
  logic [20:0] exp_q[$];

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                 S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                 S_ALUWB = 8, S_BEQ = 9, S_JAL = 10;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .alucontrol(alucontrol), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic supported(input logic [6:0] o);
    return (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
            o == OP_BEQ || o == OP_JAL);
  endfunction

  // Expected outputs for one cycle spent in step s.
  function automatic logic [20:0] exp_out(input int s, input logic [6:0] o,
      input logic [2:0] f3, input logic f7, input logic zr, input logic mr);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] ac, fn;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; ac = 3'b000;
    imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 : (o == OP_JAL) ? 2'b11 : 2'b00;
    case (f3)
      3'b000:  fn = (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  fn = 3'b101;
      3'b110:  fn = 3'b011;
      3'b111:  fn = 3'b010;
      default: fn = 3'b000;
    endcase
    case (s)
      S_FETCH:    begin sb = 2; rs = 2; irw = mr; pcw = mr; end
      S_DECODE:   begin sa = 1; sb = 1; ill = !supported(o); end
      S_MEMADR:   begin sa = 2; sb = 1; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin rs = 1; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR:    begin sa = 2; ac = fn; end
      S_EXECI:    begin sa = 2; sb = 1; ac = fn; end
      S_ALUWB:    rw = 1;
      S_BEQ:      begin sa = 2; ac = 3'b001; pcw = zr; end
      S_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    return {s[3:0], pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac, ill};
  endfunction

  // ---------------- driver ----------------
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  task automatic do_cycle(input int s, input logic mr, input logic zr);
    @(posedge clk);
    #1;
    op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
    mem_ready = mr; zero = zr;
    exp_q.push_back(exp_out(s, cur_op, cur_f3, cur_f7, zr, mr));
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction as a trace of steps: fstall waits in FETCH, mstall waits
  // in the memory-access step.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
      input logic f7, input logic zr, input int fstall, input int mstall);
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
    for (int i = 0; i < fstall; i++) do_cycle(S_FETCH, 1'b0, rb());
    do_cycle(S_FETCH, 1'b1, rb());
    do_cycle(S_DECODE, rb(), rb());
    case (o)
      OP_LW: begin
        do_cycle(S_MEMADR, rb(), rb());
        for (int i = 0; i < mstall; i++) do_cycle(S_MEMREAD, 1'b0, rb());
        do_cycle(S_MEMREAD, 1'b1, rb());
        do_cycle(S_MEMWB, rb(), rb());
      end
      OP_SW: begin
        do_cycle(S_MEMADR, rb(), rb());
        for (int i = 0; i < mstall; i++) do_cycle(S_MEMWRITE, 1'b0, rb());
        do_cycle(S_MEMWRITE, 1'b1, rb());
      end
      OP_R:   begin do_cycle(S_EXECR, rb(), rb()); do_cycle(S_ALUWB, rb(), rb()); end
      OP_I:   begin do_cycle(S_EXECI, rb(), rb()); do_cycle(S_ALUWB, rb(), rb()); end
      OP_BEQ: do_cycle(S_BEQ, rb(), zr);
      OP_JAL: begin do_cycle(S_JAL, rb(), rb()); do_cycle(S_ALUWB, rb(), rb()); end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [20:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dbg_state, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
           alusrca, alusrcb, immsrc, alucontrol, illegal_op};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL trace op=%b f3=%b: got=%h expected=%h", op, funct3, a, e);
      end
    end
  end

  task automatic check_lit(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, act, req);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    logic [6:0] o;
    int k;
    // Reset state with mem_ready high: enables must stay off.
    rst_n = 1'b0;
    mem_ready = 1'b1;
    op = OP_SW;
    #3;
    check_lit("rst_state", dbg_state, 4'd0);
    check_lit("rst_irwrite", {3'b0, irwrite}, 4'd0);
    check_lit("rst_pcwrite", {3'b0, pcwrite}, 4'd0);
    check_lit("rst_alusrcb", {2'b0, alusrcb}, 4'd2);
    check_lit("rst_resultsrc", {2'b0, resultsrc}, 4'd2);

    // Reset asserted during MEMWRITE.
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;            // -> DECODE
    @(posedge clk); #1;            // -> MEMADR
    mem_ready = 1'b0;
    @(posedge clk); #1;            // -> MEMWRITE
    check_lit("sw_memwrite", {3'b0, memwrite}, 4'd1);
    check_lit("sw_state", dbg_state, 4'd5);
    rst_n = 1'b0;
    #1;
    check_lit("abort_memwrite", {3'b0, memwrite}, 4'd0);
    check_lit("abort_state", dbg_state, 4'd0);

    // FETCH held by mem_ready low for 3 cycles.
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_lit("stall_irwrite", {3'b0, irwrite}, 4'd0);
      check_lit("stall_pcwrite", {3'b0, pcwrite}, 4'd0);
      check_lit("stall_state", dbg_state, 4'd0);
    end

    // R-type sub: alucontrol=001 in EXECR.
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;            // -> DECODE
    @(posedge clk); #1;            // -> EXECR
    check_lit("sub_alucontrol", {1'b0, alucontrol}, 4'd1);
    @(posedge clk); #1;            // -> ALUWB
    check_lit("aluwb_regwrite", {3'b0, regwrite}, 4'd1);
    // Illegal opcode pulse in DECODE.
    op = 7'b0000000;
    @(posedge clk); #1;            // -> FETCH
    @(posedge clk); #1;            // -> DECODE
    check_lit("illegal_pulse", {3'b0, illegal_op}, 4'd1);
    @(posedge clk); #1;            // -> FETCH
    check_lit("illegal_next", dbg_state, 4'd0);
    check_lit("illegal_clear", {3'b0, illegal_op}, 4'd0);
    mem_ready = 1'b0;

    // Trace-checked directed set, starting from a clean reset.
    do_reset();
    run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 3, 2);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: o = OP_LW;
        1: o = OP_SW;
        2: o = OP_R;
        3: o = OP_I;
        4: o = OP_BEQ;
        5: o = OP_JAL;
        default: o = 7'($urandom_range(0, 127));
      endcase
      run_instr(o, 3'($urandom_range(0, 7)), rb(), rb(),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
